// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter: parity modes,
// transmitter FSM states and the parity helper.
package uart_pkg;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_ODD    = 1;
  localparam int PARITY_EVEN   = 2;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Even parity is the XOR of the active data bits; odd parity inverts it.
  function automatic logic calcParity(input logic [MAX_DATA_BITS-1:0] data,
                                      input int nBits,
                                      input int mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < nBits) x = x ^ data[i];
    end
    return (mode == PARITY_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit queue with occupancy count and full/empty flags.
// Pushes when full and pops when empty are ignored.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock_i,
  input  logic                     resetN_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [PW:0]      count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    doPush  = push_i && !full_o;
    doPop   = pop_i && !empty_o;
    wrPtr_d = doPush ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d = doPop ? rdPtr_q + PW'(1) : rdPtr_q;
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetN_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (resetN_i && doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: queued words are framed as start, data
// (LSB first), optional parity and stop bits, each held CLKS_PER_BIT clocks.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_clock,
  input  logic                          i_resetN,
  input  logic                          i_txBegin,
  input  logic [DATA_BITS-1:0]          i_txData,
  output logic                          o_txReady,
  output logic                          o_txBusy,
  output logic                          o_txSerial,
  output logic                          o_txDone,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifoCount
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] LAST_CLK  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [15:0]          baudCnt_q, baudCnt_d;
  logic [3:0]           bitCnt_q, bitCnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 serial_q, serial_d;
  logic                 done_q, done_d;
  logic                 overflow_q;
  logic                 loadWord, bitTick;
  logic                 fifoFull, fifoEmpty;
  logic [DATA_BITS-1:0] fifoData;
  logic [CW-1:0]        fifoCount;

  uart_tx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock_i (i_clock),
    .resetN_i(i_resetN),
    .push_i  (i_txBegin),
    .pop_i   (loadWord),
    .data_i  (i_txData),
    .data_o  (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign bitTick = (baudCnt_q == LAST_CLK);

  always_comb begin
    state_d   = state_q;
    baudCnt_d = bitTick ? '0 : baudCnt_q + 16'd1;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    done_d    = 1'b0;
    loadWord  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baudCnt_d = '0;
        bitCnt_d  = '0;
        loadWord  = !fifoEmpty;
      end
      ST_START: begin
        if (bitTick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bitTick) begin
          shift_d = shift_q >> 1;
          if (bitCnt_q == LAST_DATA) begin
            bitCnt_d = '0;
            state_d  = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bitTick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bitTick) begin
          if (bitCnt_q == LAST_STOP) begin
            done_d   = 1'b1;
            bitCnt_d = '0;
            state_d  = ST_IDLE;
            loadWord = !fifoEmpty;
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop starts the next frame on the same edge, so frames run back to back.
    if (loadWord) begin
      state_d  = ST_START;
      shift_d  = fifoData;
      parity_d = calcParity(MAX_DATA_BITS'(fifoData), DATA_BITS, PARITY);
    end

    case (state_d)
      ST_START:  serial_d = 1'b0;
      ST_DATA:   serial_d = shift_d[0];
      ST_PARITY: serial_d = parity_d;
      default:   serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_resetN) begin
      state_q    <= ST_IDLE;
      baudCnt_q  <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      serial_q   <= 1'b1;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baudCnt_q  <= baudCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      serial_q   <= serial_d;
      done_q     <= done_d;
      overflow_q <= i_txBegin && fifoFull;
    end
  end

  assign o_txReady   = !fifoFull;
  assign o_txBusy    = (state_q != ST_IDLE) || !fifoEmpty;
  assign o_txSerial  = serial_q;
  assign o_txDone    = done_q;
  assign o_overflow  = overflow_q;
  assign o_fifoCount = fifoCount;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: four instances cover no parity, even,
// odd, and 5-bit/2-stop framing; a monitor decodes every frame on the line.
module tb_uart_tx_cfg;

  localparam int NU  = 4;
  localparam int CPB = 4;

  function automatic int dbOf(input int g);
    return (g == 3) ? 5 : 8;
  endfunction
  function automatic int parOf(input int g);
    return (g == 1) ? 2 : ((g == 2) ? 1 : 0);
  endfunction
  function automatic int stopOf(input int g);
    return (g == 3) ? 2 : 1;
  endfunction
  function automatic int frameBits(input int g);
    return 1 + dbOf(g) + ((parOf(g) != 0) ? 1 : 0) + stopOf(g);
  endfunction

  logic                  clock = 1'b0;
  logic [NU-1:0]         resetN;
  logic [NU-1:0]         txBegin;
  logic [7:0]            txData [NU];
  logic [NU-1:0]         txReady, txBusy, txSerial, txDone, overflow;
  logic [NU-1:0][2:0]    fifoCount;

  logic [15:0]           expQ [NU][$];
  int                    doneCnt [NU];
  int                    ovfCnt [NU];
  int                    pos [NU];
  logic [15:0]           capBits [NU];
  bit                    stable [NU];
  int                    checks = 0;
  int                    failures = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NU; g++) begin : gen_dut
    localparam int DB = dbOf(g);
    uart_tx_cfg #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB),
      .PARITY      (parOf(g)),
      .STOP_BITS   (stopOf(g)),
      .FIFO_DEPTH  (4)
    ) dut (
      .i_clock    (clock),
      .i_resetN   (resetN[g]),
      .i_txBegin  (txBegin[g]),
      .i_txData   (txData[g][DB-1:0]),
      .o_txReady  (txReady[g]),
      .o_txBusy   (txBusy[g]),
      .o_txSerial (txSerial[g]),
      .o_txDone   (txDone[g]),
      .o_overflow (overflow[g]),
      .o_fifoCount(fifoCount[g])
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // One-cycle write to instance k; the hand-computed frame is queued when push is set.
  task automatic applyStimulus(input int k, input logic [7:0] word,
                               input logic [15:0] expFrame, input bit push);
    txBegin[k] = 1'b1;
    txData[k]  = word;
    if (push) expQ[k].push_back(expFrame);
    @(posedge clock);
    #1;
    txBegin[k] = 1'b0;
  endtask

  task automatic waitDrain(input int k);
    int n;
    n = 0;
    while ((expQ[k].size() != 0 || txBusy[k]) && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput($sformatf("drain_u%0d", k), (n < 3000), 1'b1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    for (int k = 0; k < NU; k++) begin
      if (txDone[k] === 1'b1) doneCnt[k]++;
      if (overflow[k] === 1'b1) ovfCnt[k]++;
    end
  end

  // Monitor: samples each line every cycle from the start-bit fall, checks
  // every bit is held CPB cycles, that done pulses right after the frame,
  // and compares the captured frame with the scoreboard head.
  initial begin
    for (int k = 0; k < NU; k++) pos[k] = -1;
    forever begin
      @(negedge clock);
      for (int k = 0; k < NU; k++) begin
        if (resetN[k] !== 1'b1) begin
          pos[k] = -1;
        end else begin
          if (pos[k] == frameBits(k) * CPB) begin
            checkOutput($sformatf("done_timing_u%0d", k), txDone[k], 1'b1);
            checkOutput($sformatf("bit_width_u%0d", k), stable[k], 1'b1);
            if (expQ[k].size() == 0)
              checkOutput($sformatf("unexpected_frame_u%0d", k), capBits[k], 16'hFFFF);
            else
              checkOutput($sformatf("frame_u%0d", k), capBits[k], expQ[k].pop_front());
            pos[k] = -1;
          end
          if (pos[k] < 0 && txSerial[k] === 1'b0) begin
            pos[k]     = 0;
            capBits[k] = '0;
            stable[k]  = 1'b1;
          end
          if (pos[k] >= 0) begin
            if (pos[k] % CPB == 0) capBits[k][pos[k] / CPB] = txSerial[k];
            else if (txSerial[k] !== capBits[k][pos[k] / CPB]) stable[k] = 1'b0;
            pos[k]++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] ovfExp [6];
    int d0, o0;
    ovfExp = '{16'h202, 16'h204, 16'h206, 16'h208, 16'h20A, 16'h000};
    resetN  = '0;
    txBegin = '0;
    for (int k = 0; k < NU; k++) begin
      txData[k]  = '0;
      doneCnt[k] = 0;
      ovfCnt[k]  = 0;
    end
    repeat (3) @(posedge clock);
    #1;
    // {serial, busy, done, overflow, ready, count}
    for (int k = 0; k < NU; k++)
      checkOutput($sformatf("reset_state_u%0d", k),
                  {txSerial[k], txBusy[k], txDone[k], overflow[k], txReady[k], fifoCount[k]},
                  {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
    resetN = '1;
    repeat (2) @(posedge clock);
    #1;

    // 0xCC: start 0, data 0,0,1,1,0,0,1,1, stop 1
    d0 = doneCnt[0];
    applyStimulus(0, 8'hCC, 16'h398, 1'b1);
    checkOutput("line_high_at_write_edge", txSerial[0], 1'b1);
    @(posedge clock);
    #1;
    checkOutput("start_one_edge_later", txSerial[0], 1'b0);
    waitDrain(0);
    checkOutput("done_count_single", doneCnt[0] - d0, 1);

    // Back to back: the second start bit must replace the first frame's end.
    d0 = doneCnt[0];
    applyStimulus(0, 8'hCC, 16'h398, 1'b1);
    applyStimulus(0, 8'hDD, 16'h3BA, 1'b1);
    repeat (40) @(posedge clock);
    #1;
    checkOutput("b2b_done_and_start", {txDone[0], txSerial[0], txBusy[0]}, 3'b101);
    waitDrain(0);
    checkOutput("done_count_b2b", doneCnt[0] - d0, 2);

    // Even parity: 0x07 -> 1, 0x03 -> 0; odd parity is the inverse.
    applyStimulus(1, 8'h07, 16'h60E, 1'b1);
    applyStimulus(1, 8'h03, 16'h406, 1'b1);
    applyStimulus(2, 8'h07, 16'h40E, 1'b1);
    applyStimulus(2, 8'h03, 16'h606, 1'b1);
    // 5 data bits, 2 stop bits: 0x1F -> 0,1,1,1,1,1,1,1 ; 0x0A -> 0,0,1,0,1,0,1,1
    applyStimulus(3, 8'h1F, 16'h0FE, 1'b1);
    applyStimulus(3, 8'h0A, 16'h0D4, 1'b1);
    waitDrain(1);
    waitDrain(2);
    waitDrain(3);

    // Six consecutive writes: the first is popped on the second write's edge,
    // four more fill the queue, the sixth is rejected.
    d0 = doneCnt[0];
    o0 = ovfCnt[0];
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 8'(i + 1), ovfExp[i], (i < 5));
      if (i == 1) checkOutput("count_write_and_pop", fifoCount[0], 3'd1);
      if (i == 4) checkOutput("full_count_ready", {fifoCount[0], txReady[0]}, {3'd4, 1'b0});
      if (i == 5) checkOutput("overflow_pulse", overflow[0], 1'b1);
    end
    @(posedge clock);
    #1;
    checkOutput("overflow_one_cycle", overflow[0], 1'b0);
    waitDrain(0);
    checkOutput("overflow_count", ovfCnt[0] - o0, 1);
    checkOutput("done_count_five", doneCnt[0] - d0, 5);

    // Reset during the data bits aborts the frame without a done pulse.
    d0 = doneCnt[0];
    applyStimulus(0, 8'h3C, 16'h000, 1'b0);
    repeat (7) @(posedge clock);
    #1;
    resetN[0] = 1'b0;
    @(posedge clock);
    #1;
    resetN[0] = 1'b1;
    checkOutput("abort_line_count_busy", {txSerial[0], fifoCount[0], txBusy[0]}, {1'b1, 3'd0, 1'b0});
    repeat (45) @(posedge clock);
    #1;
    checkOutput("abort_no_done", doneCnt[0] - d0, 0);
    applyStimulus(0, 8'hA5, 16'h34A, 1'b1);
    waitDrain(0);
    checkOutput("done_after_abort", doneCnt[0] - d0, 1);

    for (int k = 0; k < NU; k++)
      checkOutput($sformatf("queue_empty_u%0d", k), expQ[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
